// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for a multiply-by-repeated-addition datapath
// (A register, P accumulator, B down-counter, adder, zero comparator).
// It takes operand pairs over op_valid/op_ready, drives the shared data bus
// and every datapath strobe, and returns the product mod 2^WIDTH with an
// overflow flag over res_valid/res_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   op_valid/op_ready   operand handshake (ready only while idle)
//   op_a, op_b          multiplicand, multiplier (iteration count)
//   res_valid/res_ready result handshake
//   res_data, res_ovf   truncated product, true-product-overflow flag
//   bus_out             datapath data_in
//   ld_a, ld_b, ld_p    datapath register loads
//   clr_p, dec_b        datapath P clear, B decrement
//   eqz                 datapath B==0
//   p_in, sum_in        datapath P register and adder output (A+P)
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic [WIDTH-1:0] bus_out,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_p,
  output logic             clr_p,
  output logic             dec_b,
  input  logic             eqz,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] sum_in
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] res_data_d;
  logic             res_ovf_d;
  logic [WIDTH-1:0] bus_d;
  logic             op_ready_d, res_valid_d;
  logic             ld_a_d, ld_b_d, clr_p_d;
  logic             run_q, run_d;

  // RUN iteration strobes: registered RUN flag gated by the live zero flag,
  // so the P load and B decrement happen in the same cycle eqz is seen low.
  assign ld_p  = run_q & ~eqz;
  assign dec_b = run_q & ~eqz;

  // Next state, datapath-facing values and next registered outputs.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sticky_d   = sticky_q;
    res_data_d = res_data;
    res_ovf_d  = res_ovf;
    bus_d      = bus_out;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready) begin
          a_d      = op_a;
          b_d      = op_b;
          sticky_d = 1'b0;
          bus_d    = op_a;
          state_d  = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        bus_d   = b_q;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        bus_d   = b_q;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (eqz) begin
          res_data_d = p_in;
          res_ovf_d  = sticky_q;
          state_d    = S_OUT;
        end else if (sum_in < p_in) begin
          // Adder carry-out: the true product no longer fits.
          sticky_d = 1'b1;
        end
      end
      S_OUT: begin
        if (res_valid && res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs follow the state being entered.
    op_ready_d  = (state_d == S_IDLE);
    ld_a_d      = (state_d == S_LOAD_A);
    ld_b_d      = (state_d == S_LOAD_B);
    clr_p_d     = (state_d == S_LOAD_B);
    run_d       = (state_d == S_RUN);
    res_valid_d = (state_d == S_OUT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sticky_q  <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      bus_out   <= '0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      clr_p     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sticky_q  <= sticky_d;
      res_data  <= res_data_d;
      res_ovf   <= res_ovf_d;
      bus_out   <= bus_d;
      op_ready  <= op_ready_d;
      res_valid <= res_valid_d;
      ld_a      <= ld_a_d;
      ld_b      <= ld_b_d;
      clr_p     <= clr_p_d;
      run_q     <= run_d;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural repeated-addition
// datapath attached to its strobes.
module tb_mul_seq_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic [WIDTH-1:0] bus_out;
  logic             ld_a, ld_b, ld_p, clr_p, dec_b;
  logic             eqz;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] sum_in;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf),
    .bus_out(bus_out), .ld_a(ld_a), .ld_b(ld_b), .ld_p(ld_p),
    .clr_p(clr_p), .dec_b(dec_b),
    .eqz(eqz), .p_in(p_in), .sum_in(sum_in)
  );

  // Datapath model: not reset, as in the real datapath.
  logic [WIDTH-1:0] dp_a = '0;
  logic [WIDTH-1:0] dp_b = '0;
  logic [WIDTH-1:0] dp_p = '0;

  always @(posedge clk) begin
    if (ld_a) dp_a <= bus_out;
    if (ld_b) dp_b <= bus_out;
    else if (dec_b) dp_b <= dp_b - WIDTH'(1);
    if (clr_p) dp_p <= '0;
    else if (ld_p) dp_p <= dp_a + dp_p;
  end

  assign eqz    = (dp_b == '0);
  assign p_in   = dp_p;
  assign sum_in = dp_a + dp_p;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] strobe_vec();
    return {26'b0, op_ready, ld_a, ld_b, clr_p, ld_p, dec_b};
  endfunction

  // One operation from the current negedge: accept, per-cycle strobe
  // schedule, latency, result, optional backpressure, result handshake.
  // nv/na/nb are the operand inputs presented once the op is accepted.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_data, input logic exp_ovf,
                        input int hold, input logic early_rdy,
                        input logic nv, input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                        output int waited);
    int n;
    int pulses;
    int bi;
    logic [31:0] exp_vec;
    logic        exp_lp;
    bi        = int'(b);
    op_a      = a;
    op_b      = b;
    op_valid  = 1'b1;
    res_ready = early_rdy;
    waited    = 0;
    while (!op_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check_val("op_ready_at_accept", 32'(op_ready), 32'd1);
    @(negedge clk);
    n        = 1;
    pulses   = 0;
    op_valid = nv;
    op_a     = na;
    op_b     = nb;
    while (!res_valid && n <= bi + 10) begin
      exp_lp  = (n >= 3) && (n < 3 + bi);
      exp_vec = {26'b0, 1'b0, 1'(n == 1), 1'(n == 2), 1'(n == 2), exp_lp, exp_lp};
      check_val("strobes", strobe_vec(), exp_vec);
      if (n == 1) check_val("bus_a", 32'(bus_out), 32'(a));
      if (n == 2) check_val("bus_b", 32'(bus_out), 32'(b));
      if (ld_p) pulses++;
      @(negedge clk);
      n++;
    end
    check_val("res_valid_latency", 32'(n), 32'(bi + 4));
    check_val("res_valid", 32'(res_valid), 32'd1);
    check_val("ld_p_pulses", 32'(pulses), 32'(bi));
    check_val("res_data", 32'(res_data), 32'(exp_data));
    check_val("res_ovf", 32'(res_ovf), 32'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'(i % 2);
      op_a     = 16'hFFFF;
      op_b     = 16'd1;
      @(negedge clk);
      check_val("hold_res_data", 32'(res_data), 32'(exp_data));
      check_val("hold_busy", {30'b0, op_ready, res_valid}, 32'b01);
    end
    op_valid  = nv;
    op_a      = na;
    op_b      = nb;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_val("post_hs_idle", {30'b0, op_ready, res_valid}, 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    rst       = 1'b1;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_strobes", strobe_vec(), 32'd0);
    check_val("rst_res", {14'b0, res_valid, res_ovf, res_data}, 32'd0);
    check_val("rst_bus", 32'(bus_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("op_ready_after_rst", 32'(op_ready), 32'd1);

    // Plan 1: 17 x 5
    run_op(16'd17, 16'd5, 16'd85, 1'b0, 0, 1'b0, 1'b0, '0, '0, w);
    // Plan 2: B=0, then A=0 with res_ready already high
    run_op(16'd1234, 16'd0, 16'd0, 1'b0, 0, 1'b0, 1'b0, '0, '0, w);
    run_op(16'd0, 16'd3, 16'd0, 1'b0, 0, 1'b1, 1'b0, '0, '0, w);
    // Plan 3: overflow, then sticky cleared
    run_op(16'd300, 16'd300, 16'd24464, 1'b1, 0, 1'b0, 1'b0, '0, '0, w);
    run_op(16'd2, 16'd3, 16'd6, 1'b0, 0, 1'b0, 1'b0, '0, '0, w);
    // Plan 4: backpressure with ignored op_valid pulses
    run_op(16'd25, 16'd4, 16'd100, 1'b0, 10, 1'b0, 1'b0, '0, '0, w);
    run_op(16'd6, 16'd7, 16'd42, 1'b0, 0, 1'b0, 1'b0, '0, '0, w);
    check_val("accept_after_bp_wait", 32'(w), 32'd0);
    // Plan 5: back-to-back with op_valid held high
    run_op(16'd3, 16'd4, 16'd12, 1'b0, 0, 1'b0, 1'b1, 16'd7, 16'd2, w);
    run_op(16'd7, 16'd2, 16'd14, 1'b0, 0, 1'b0, 1'b0, '0, '0, w);
    check_val("b2b_accept_wait", 32'(w), 32'd0);

    // Plan 6: asynchronous reset mid-RUN
    op_a     = 16'd100;
    op_b     = 16'd50;
    op_valid = 1'b1;
    w        = 0;
    while (!op_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_val("ld_p_before_rst", 32'(ld_p), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("async_rst_strobes", strobe_vec(), 32'd0);
    check_val("async_rst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("op_ready_after_rst2", 32'(op_ready), 32'd1);
    run_op(16'd9, 16'd9, 16'd81, 1'b0, 0, 1'b0, 1'b0, '0, '0, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
